// File: rtl/layer_top_mul_arbiter.sv
// layer_top_mul_arbiter
//   Shares one A_W-bit unsigned x B_W-bit signed multiplier between NREQ
//   requesters. A round-robin arbiter feeds a two-stage pipeline (operand
//   register, then product register); results return on one response
//   channel tagged with the issuing requester id.
//   Optional build macro: LAYER_MUL_ARB_PRIO_EN gives requester 0 absolute
//   priority, with round-robin among the remaining requesters.
`timescale 1ns/1ps

module layer_top_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int A_W  = 15,
  parameter int B_W  = 16,
  parameter int P_W  = 29,
  parameter int ID_W = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*A_W-1:0]  req_a,
  input  logic [NREQ*B_W-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [P_W-1:0]       rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [31:0]          op_count
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // reset synchroniser: assertion is immediate, release waits two edges
  logic [1:0]            rst_sync_r;
  logic                  rst_int_n_s;

  // arbitration enable, raised one cycle after internal reset release
  logic                  arb_en_r;

  // pipeline state
  logic                  s1_valid_r;
  logic [A_W-1:0]        s1_a_r;
  logic [B_W-1:0]        s1_b_r;
  logic [ID_W-1:0]       s1_id_r;
  logic                  s2_valid_r;
  logic [P_W-1:0]        s2_data_r;
  logic [ID_W-1:0]       s2_id_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [31:0]           op_count_r;

  // combinational control
  logic                  s2_adv_s;
  logic                  s1_free_s;
  logic                  rsp_fire_s;
  logic                  grant_found_s;
  logic [SEL_W-1:0]      arb_idx_s;
  logic [SEL_W-1:0]      cand_s;
  logic                  hit_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic                  grant_ok_s;
  logic                  accept_s;
  logic [NREQ-1:0]       req_ready_s;
  logic [A_W-1:0]        sel_a_s;
  logic [B_W-1:0]        sel_b_s;
  logic                  ptr_upd_s;
  logic [ID_W-1:0]       ptr_next_s;
  logic signed [P_W-1:0] mul_a_s;
  logic signed [P_W-1:0] mul_b_s;
  logic signed [P_W-1:0] prod_s;
`ifdef LAYER_MUL_ARB_PRIO_EN
  int                    arb_base_s;
`endif

  // two-flop reset synchroniser for the internal reset net
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // stage-advance conditions; a pop and a refill may share one cycle
  assign s2_adv_s   = s1_valid_r & (~s2_valid_r | rsp_ready);
  assign s1_free_s  = ~s1_valid_r | s2_adv_s;
  assign rsp_fire_s = s2_valid_r & rsp_ready;

  // winner search starting at the round-robin pointer
  always_comb begin
    grant_found_s = 1'b0;
    arb_idx_s     = {SEL_W{1'b0}};
    cand_s        = {SEL_W{1'b0}};
    hit_s         = 1'b0;
`ifdef LAYER_MUL_ARB_PRIO_EN
    arb_base_s    = 1;
    if (req_valid[0]) begin
      grant_found_s = 1'b1;
      arb_idx_s     = {SEL_W{1'b0}};
    end else begin
      // pointer value 0 means "start at requester 1" in this mode
      arb_base_s = (rr_ptr_r == {ID_W{1'b0}}) ? 1 : int'(rr_ptr_r);
      for (int k = 0; k < NREQ - 1; k++) begin
        cand_s        = SEL_W'(1 + ((arb_base_s - 1 + k) % (NREQ - 1)));
        hit_s         = ~grant_found_s & req_valid[cand_s];
        arb_idx_s     = hit_s ? cand_s : arb_idx_s;
        grant_found_s = grant_found_s | hit_s;
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      cand_s        = SEL_W'((int'(rr_ptr_r) + k) % NREQ);
      hit_s         = ~grant_found_s & req_valid[cand_s];
      arb_idx_s     = hit_s ? cand_s : arb_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
`endif
  end

  assign grant_idx_s = ID_W'(arb_idx_s);
  assign grant_ok_s  = grant_found_s & s1_free_s & arb_en_r;
  assign accept_s    = grant_ok_s;

  // one-hot ready towards the winner, and its operands via an and-or mux
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    sel_a_s     = {A_W{1'b0}};
    sel_b_s     = {B_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready_s[i] = grant_ok_s & (grant_idx_s == ID_W'(i));
      sel_a_s = sel_a_s | (req_a[i*A_W +: A_W] & {A_W{grant_idx_s == ID_W'(i)}});
      sel_b_s = sel_b_s | (req_b[i*B_W +: B_W] & {B_W{grant_idx_s == ID_W'(i)}});
    end
  end

  assign req_ready = req_ready_s;

`ifdef LAYER_MUL_ARB_PRIO_EN
  // requester 0 wins by priority and does not move the rotation
  assign ptr_upd_s = accept_s & (grant_idx_s != {ID_W{1'b0}});
`else
  assign ptr_upd_s = accept_s;
`endif
  assign ptr_next_s = (grant_idx_s == ID_W'(NREQ - 1)) ? {ID_W{1'b0}}
                                                        : (grant_idx_s + ID_W'(1));

  // only the low P_W product bits are needed, so operands are extended to P_W
  assign mul_a_s = P_W'($signed({1'b0, s1_a_r}));
  assign mul_b_s = P_W'($signed(s1_b_r));
  assign prod_s  = mul_a_s * mul_b_s;

  // arbitration enable follows internal reset release
  always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      arb_en_r <= 1'b0;
    end else begin
      arb_en_r <= 1'b1;
    end
  end

  // stage 1: operand capture on request handshake, drain when moved on
  always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {A_W{1'b0}};
      s1_b_r     <= {B_W{1'b0}};
      s1_id_r    <= {ID_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= sel_a_s;
      s1_b_r     <= sel_b_s;
      s1_id_r    <= grant_idx_s;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // stage 2: product register; data/id hold while empty or stalled
  always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {P_W{1'b0}};
      s2_id_r    <= {ID_W{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= prod_s;
      s2_id_r    <= s1_id_r;
    end else if (rsp_fire_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // round-robin pointer moves past each granted requester
  always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (ptr_upd_s) begin
      rr_ptr_r <= ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // completed-response counter, free-running wrap at 2^32
  always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      op_count_r <= 32'd0;
    end else if (rsp_fire_s) begin
      op_count_r <= op_count_r + 32'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_data  = s2_data_r;
  assign rsp_id    = s2_id_r;
  assign busy      = s1_valid_r | s2_valid_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_layer_top_mul_arbiter.sv
// Directed bench for layer_top_mul_arbiter (default build, round-robin).
`timescale 1ns/1ps

module tb_layer_top_mul_arbiter;

  localparam int NREQ = 4;
  localparam int A_W  = 15;
  localparam int B_W  = 16;
  localparam int P_W  = 29;
  localparam int ID_W = 2;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [P_W-1:0]      rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;
  logic [31:0]         op_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [A_W-1:0] op_a [NREQ];
  logic [B_W-1:0] op_b [NREQ];

  layer_top_mul_arbiter #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  // reference: {0,a} * signed b, low P_W bits
  function automatic logic [P_W-1:0] golden(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint p;
    p = longint'(a) * longint'($signed(b));
    return p[P_W-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int idx;
    int cnt;
    idx = -1;
    cnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        idx = i;
        cnt++;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  initial begin
    int acc;
    int found;
    int gid;
    int issued;
    int recvd;
    int cyc;
    logic [P_W-1:0]      hold_d;
    logic [ID_W-1:0]     hold_id;
    logic [NREQ-1:0]     acc_mask;
    logic [ID_W+P_W-1:0] exp_e;
    logic [ID_W+P_W-1:0] expq [$];

    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = A_W'(1000 + 37 * i);
      op_b[i] = B_W'(-(i + 1) * 123);
    end

    // reset state
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_op_count",  op_count,       32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    ap_rst_n = 1'b1;
    repeat (4) tick();

    // single op: requester 2, 100 * -3
    set_op(2, 15'd100, 16'hFFFD);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("t1_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'h1FFFFED4);
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    tick();
    check("t1_rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("t1_data_hold", 32'(rsp_data), 32'h1FFFFED4);
    check("t1_op_count", op_count, 32'd1);

    // wrap: 32767 * -32768 mod 2^29, requester 1 (pointer now at 3)
    set_op(1, 15'h7FFF, 16'h8000);
    req_valid = 4'b0010;
    #1;
    check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_data", 32'(rsp_data), 32'h0008000);
    check("t2_rsp_id", 32'(rsp_id), 32'd1);
    tick();
    check("t2_op_count", op_count, 32'd2);

    // backpressure: pointer at 2, all valid, response stalled
    for (int i = 0; i < NREQ; i++) set_op(i, op_a[i], op_b[i]);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    acc = 0;
    hold_d = '0;
    hold_id = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (|(req_valid & req_ready)) acc++;
      if (c == 2) begin
        hold_d  = rsp_data;
        hold_id = rsp_id;
      end
      tick();
    end
    check("t4_accepts", 32'(acc), 32'd2);
    check("t4_ready_zero", 32'(req_ready), 32'd0);
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t4_id_stable", 32'(rsp_id), 32'(hold_id));
    check("t4_data_stable", 32'(rsp_data), 32'(hold_d));
    check("t4_id", 32'(rsp_id), 32'd2);
    check("t4_data", 32'(rsp_data), 32'(golden(op_a[2], op_b[2])));
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("t4_drain_valid", 32'(rsp_valid), 32'd1);
    check("t4_drain_id", 32'(rsp_id), 32'd3);
    check("t4_drain_data", 32'(rsp_data), 32'(golden(op_a[3], op_b[3])));
    tick();
    check("t4_empty", 32'(rsp_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_op_count", op_count, 32'd4);

    // reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    check("t5_full_busy", 32'(busy), 32'd1);
    check("t5_full_valid", 32'(rsp_valid), 32'd1);
    check("t5_full_id", 32'(rsp_id), 32'd0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_op_count", op_count, 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) tick();
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (req_ready != '0) found = 1;
    end
    check("t5_grant_seen", 32'(found), 32'd1);
    check("t5_first_grant", 32'(req_ready), 32'h1);

    // fairness: all valid, free-flowing response
    for (int c = 0; c < 12; c++) begin
      gid = onehot_idx(req_ready);
      check("t3_grant", 32'(gid), 32'(c % 4));
      if (c >= 2) begin
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t3_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        check("t3_rsp_data", 32'(rsp_data), 32'(golden(op_a[(c - 2) % 4], op_b[(c - 2) % 4])));
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_op_count", op_count, 32'd12);

    // randomized traffic against an in-order scoreboard
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    repeat (4) tick();
    issued = 0;
    recvd  = 0;
    cyc    = 0;
    while (recvd < 1000 && cyc < 20000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && issued < 1000 && $urandom_range(0, 3) != 0) begin
          set_op(i, A_W'($urandom), B_W'($urandom));
          req_valid[i] = 1'b1;
          issued++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_mask = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          expq.push_back({ID_W'(i), golden(req_a[i*A_W +: A_W], req_b[i*B_W +: B_W])});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          check("t6_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_e = expq.pop_front();
          check("t6_rsp_id", 32'(rsp_id), 32'(exp_e[ID_W+P_W-1:P_W]));
          check("t6_rsp_data", 32'(rsp_data), 32'(exp_e[P_W-1:0]));
        end
        recvd++;
      end
      tick();
      req_valid = req_valid & ~acc_mask;
      cyc++;
    end
    check("t6_received", 32'(recvd), 32'd1000);
    check("t6_queue_empty", 32'(expq.size()), 32'd0);
    check("t6_op_count", op_count, 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
